alu_share_arbiter: RTL and testbench

//   Shares the single combinational ALU between two requesters (req0, req1) via valid/ready.

---
 rtl/alu_share_arbiter_if.sv | 53 +++++
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles every non-clock/reset signal of alu_share_arbiter: the two
//   requester valid/ready channels, the registered ALU drive and its
//   result/overflow return, the tagged response channel, the display hold
//   register, the busy flag and the sticky overflow controls.
//   modport slave  : the arbiter's view (requests in, responses out)
//   modport master : the surrounding system's view (requesters, ALU, consumer)
// Parameters: OPW operand width, RESW ALU result width.
interface alu_share_arbiter_if #(
  parameter int OPW  = 3,
  parameter int RESW = 16
);
  logic            req0_valid;
  logic [OPW-1:0]  req0_a;
  logic [OPW-1:0]  req0_b;
  logic [1:0]      req0_op;
  logic            req0_ready;
  logic            req1_valid;
  logic [OPW-1:0]  req1_a;
  logic [OPW-1:0]  req1_b;
  logic [1:0]      req1_op;
  logic            req1_ready;
  logic [OPW-1:0]  alu_a;
  logic [OPW-1:0]  alu_b;
  logic [1:0]      alu_op;
  logic [RESW-1:0] alu_out;
  logic            alu_ovf;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [RESW-1:0] rsp_data;
  logic            rsp_ovf;
  logic [RESW-1:0] disp_data;
  logic            busy;
  logic            ovf_clr;
  logic            ovf_sticky;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_out, alu_ovf, rsp_ready, ovf_clr,
    output req0_ready, req1_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_data, rsp_ovf, disp_data, busy, ovf_sticky
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_out, alu_ovf, rsp_ready, ovf_clr,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_data, rsp_ovf, disp_data, busy, ovf_sticky
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two valid/ready requesters with
//   round-robin priority. An accepted request's operands and opcode are
//   registered onto the ALU inputs, held for SETTLE_CYCLES cycles, then the
//   ALU result and overflow are captured and offered as a response tagged
//   with the requester id. The last handed-off result is held on disp_data.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_arbiter_if.slave (requests, ALU drive/return, response,
//          disp_data, busy, ovf_clr, ovf_sticky)
// Optional feature: define ALU_ARB_OVF_STICKY_EN to build the sticky
//   overflow flag; otherwise ovf_sticky is tied 0 and ovf_clr is ignored.
module alu_share_arbiter #(
  parameter int OPW           = 3,
  parameter int RESW          = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  // A settle time of zero still needs one cycle for the ALU to see its inputs.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNTW       = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]  alu_a_q, alu_a_d;
  logic [OPW-1:0]  alu_b_q, alu_b_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic            rsp_id_q, rsp_id_d;
  logic [RESW-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic [RESW-1:0] disp_data_q, disp_data_d;
  logic            grant0, grant1;
  logic            handshake;

  // Round-robin: a lone requester always wins; a tie goes to prio_q.
  // Ready is also masked by rst_n so nothing is accepted during reset.
  always_comb begin
    grant0    = bus.req0_valid && (!bus.req1_valid || !prio_q);
    grant1    = bus.req1_valid && (!bus.req0_valid ||  prio_q);
    handshake = (state_q == RESP) && bus.rsp_ready;
  end

  assign bus.req0_ready = rst_n && (state_q == IDLE) && grant0;
  assign bus.req1_ready = rst_n && (state_q == IDLE) && grant1;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.busy       = (state_q != IDLE);

  // Next-state and datapath: accept in IDLE, count down in EXEC, hold the
  // response in RESP until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    disp_data_d = disp_data_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          alu_a_d  = grant1 ? bus.req1_a  : bus.req0_a;
          alu_b_d  = grant1 ? bus.req1_b  : bus.req0_b;
          alu_op_d = grant1 ? bus.req1_op : bus.req0_op;
          rsp_id_d = grant1;
          cnt_d    = CNT_LOAD;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d = bus.alu_out;
          rsp_ovf_d  = bus.alu_ovf;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          disp_data_d = rsp_data_q;
          prio_d      = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      disp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      disp_data_q <= disp_data_d;
    end
  end

`ifdef ALU_ARB_OVF_STICKY_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // Clear first so that a set in the same cycle wins.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (bus.ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
    if (handshake && rsp_ovf_q) begin
      ovf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign bus.ovf_sticky = ovf_sticky_q;
`else
  logic unused_sticky_inputs;

  assign unused_sticky_inputs = bus.ovf_clr ^ handshake;
  assign bus.ovf_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter with a transaction-level reference model,
//   a per-cycle compare process and directed scenarios with literal checks.
module tb_alu_share_arbiter;

  localparam int OPW    = 3;
  localparam int RESW   = 16;
  localparam int SETTLE = 1;
`ifdef ALU_ARB_OVF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic ovf_in;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  bit   compare_en;
  bit   mon_en;
  int   grant_id[$];
  int   grant_cyc[$];

  alu_share_arbiter_if #(.OPW(OPW), .RESW(RESW)) bus ();

  alu_share_arbiter #(.OPW(OPW), .RESW(RESW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // The shared ALU: add, subtract, multiply, xor, zero-extended to RESW.
  function automatic logic [RESW-1:0] alu_fn(input logic [OPW-1:0] a,
                                             input logic [OPW-1:0] b,
                                             input logic [1:0] op);
    logic [RESW-1:0] ea;
    logic [RESW-1:0] eb;
    ea = RESW'(a);
    eb = RESW'(b);
    case (op)
      2'd0:    return ea + eb;
      2'd1:    return ea - eb;
      2'd2:    return ea * eb;
      default: return ea ^ eb;
    endcase
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_ovf = ovf_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: an operation is either absent, counting down its
  // settle time, or waiting to be taken by the consumer.
  bit              m_holding;
  int              m_left;
  bit              m_prio;
  bit              m_id;
  logic [OPW-1:0]  m_a, m_b;
  logic [1:0]      m_op;
  logic [RESW-1:0] m_data;
  bit              m_ovf;
  logic [RESW-1:0] m_disp;
  bit              m_sticky;

  function automatic bit m_idle();
    return !m_holding && (m_left == 0);
  endfunction

  function automatic bit exp_ready(input bit id);
    bit mine, other;
    mine  = id ? bus.req1_valid : bus.req0_valid;
    other = id ? bus.req0_valid : bus.req1_valid;
    return rst_n && m_idle() && mine && (!other || (m_prio == id));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_holding <= 1'b0;
      m_left    <= 0;
      m_prio    <= 1'b0;
      m_id      <= 1'b0;
      m_a       <= '0;
      m_b       <= '0;
      m_op      <= '0;
      m_data    <= '0;
      m_ovf     <= 1'b0;
      m_disp    <= '0;
      m_sticky  <= 1'b0;
    end else begin
      if (STICKY && bus.ovf_clr) m_sticky <= 1'b0;
      if (m_holding) begin
        if (bus.rsp_ready) begin
          m_disp    <= m_data;
          m_prio    <= !m_id;
          m_holding <= 1'b0;
          if (STICKY && m_ovf) m_sticky <= 1'b1;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_data    <= alu_fn(m_a, m_b, m_op);
          m_ovf     <= ovf_in;
          m_holding <= 1'b1;
        end
      end else if (exp_ready(1'b0) || exp_ready(1'b1)) begin
        m_id   <= exp_ready(1'b1);
        m_a    <= exp_ready(1'b1) ? bus.req1_a  : bus.req0_a;
        m_b    <= exp_ready(1'b1) ? bus.req1_b  : bus.req0_b;
        m_op   <= exp_ready(1'b1) ? bus.req1_op : bus.req0_op;
        m_left <= SETTLE;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h",
               name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("ready0", 32'(bus.req0_ready), 32'(exp_ready(1'b0)));
      checkOutput("ready1", 32'(bus.req1_ready), 32'(exp_ready(1'b1)));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(m_holding));
      checkOutput("busy", 32'(bus.busy), 32'(!m_idle()));
      checkOutput("disp_data", 32'(bus.disp_data), 32'(m_disp));
      checkOutput("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_sticky));
      checkOutput("alu_a", 32'(bus.alu_a), 32'(m_a));
      checkOutput("alu_b", 32'(bus.alu_b), 32'(m_b));
      checkOutput("alu_op", 32'(bus.alu_op), 32'(m_op));
      if (m_holding) begin
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(m_data));
        checkOutput("rsp_ovf", 32'(bus.rsp_ovf), 32'(m_ovf));
      end
    end
    if (mon_en) begin
      if (bus.req0_ready) begin grant_id.push_back(0); grant_cyc.push_back(cyc); end
      if (bus.req1_ready) begin grant_id.push_back(1); grant_cyc.push_back(cyc); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v0, input logic [OPW-1:0] a0,
                               input logic [OPW-1:0] b0, input logic [1:0] op0,
                               input bit v1, input logic [OPW-1:0] a1,
                               input logic [OPW-1:0] b1, input logic [1:0] op1);
    bus.req0_valid = v0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req0_op    = op0;
    bus.req1_valid = v1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    bus.req1_op    = op1;
  endtask

  task automatic idleReqs();
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0);
  endtask

  initial begin
    bit seen;
    logic [RESW-1:0] held;
    cyc        = 0;
    n_cmp      = 0;
    n_fail     = 0;
    compare_en = 1'b0;
    mon_en     = 1'b0;
    ovf_in     = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    rst_n = 1'b0;

    // Reset with both requesters asking.
    applyStimulus(1'b1, 3'd1, 3'd2, 2'd0, 1'b1, 3'd4, 3'd5, 2'd1);
    #2;
    checkOutput("rst_ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("rst_ready1", 32'(bus.req1_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_alu_a", 32'(bus.alu_a), 32'd0);
    checkOutput("rst_disp", 32'(bus.disp_data), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    compare_en = 1'b1;
    tick();
    tick();
    idleReqs();
    rst_n = 1'b1;
    tick();

    // Single request 3+2 from requester 0.
    applyStimulus(1'b1, 3'd3, 3'd2, 2'd0, 1'b0, '0, '0, 2'd0);
    @(negedge clk);
    checkOutput("t2_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    idleReqs();
    @(negedge clk);
    checkOutput("t2_busy_exec", 32'(bus.busy), 32'd1);
    checkOutput("t2_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t2_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("t2_rsp_data", 32'(bus.rsp_data), 32'h0005);
    @(negedge clk);
    checkOutput("t2_disp", 32'(bus.disp_data), 32'h0005);
    checkOutput("t2_rsp_drop", 32'(bus.rsp_valid), 32'd0);

    // Back-to-back contention after a fresh reset.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    grant_id.delete();
    grant_cyc.delete();
    mon_en = 1'b1;
    applyStimulus(1'b1, 3'd1, 3'd1, 2'd0, 1'b1, 3'd7, 3'd7, 2'd2);
    repeat (12) tick();
    idleReqs();
    mon_en = 1'b0;
    repeat (4) tick();
    checkOutput("t3_grant_count", 32'(grant_id.size() >= 4), 32'd1);
    if (grant_id.size() >= 4) begin
      checkOutput("t3_grant0", 32'(grant_id[0]), 32'd0);
      checkOutput("t3_grant1", 32'(grant_id[1]), 32'd1);
      checkOutput("t3_grant2", 32'(grant_id[2]), 32'd0);
      checkOutput("t3_grant3", 32'(grant_id[3]), 32'd1);
      for (int i = 1; i < 4; i++)
        checkOutput("t3_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
    end

    // Consumer stalls the response for five cycles.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 3'd5, 3'd3, 2'd1);
    @(negedge clk);
    checkOutput("t4_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 3'd6, 3'd1, 2'd3, 1'b0, '0, '0, 2'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    checkOutput("t4_rsp_seen", 32'(seen), 32'd1);
    held = bus.rsp_data;
    repeat (5) begin
      checkOutput("t4_hold_data", 32'(bus.rsp_data), 32'h0002);
      checkOutput("t4_hold_same", 32'(bus.rsp_data), 32'(held));
      checkOutput("t4_hold_id", 32'(bus.rsp_id), 32'd1);
      checkOutput("t4_hold_busy", 32'(bus.busy), 32'd1);
      checkOutput("t4_no_ready0", 32'(bus.req0_ready), 32'd0);
      @(negedge clk);
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("t4_ready0_after", 32'(bus.req0_ready), 32'd1);
    tick();
    idleReqs();
    repeat (4) tick();

    // Reset while an operation is executing.
    applyStimulus(1'b1, 3'd2, 3'd2, 2'd0, 1'b0, '0, '0, 2'd0);
    tick();
    applyStimulus(1'b1, 3'd2, 3'd2, 2'd0, 1'b1, 3'd3, 3'd3, 2'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("t5_ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("t5_alu_a", 32'(bus.alu_a), 32'd0);
    checkOutput("t5_disp", 32'(bus.disp_data), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_ready0_first", 32'(bus.req0_ready), 32'd1);
    checkOutput("t5_ready1_wait", 32'(bus.req1_ready), 32'd0);
    tick();
    idleReqs();
    repeat (4) tick();

    // Sticky overflow.
    ovf_in = 1'b1;
    applyStimulus(1'b1, 3'd1, 3'd1, 2'd1, 1'b0, '0, '0, 2'd0);
    tick();
    idleReqs();
    repeat (4) tick();
    checkOutput("t6_sticky_op1", 32'(bus.ovf_sticky), 32'(STICKY));
    ovf_in = 1'b0;
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 3'd2, 3'd3, 2'd2);
    tick();
    idleReqs();
    repeat (4) tick();
    checkOutput("t6_sticky_op2", 32'(bus.ovf_sticky), 32'(STICKY));
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("t6_sticky_clr", 32'(bus.ovf_sticky), 32'd0);
    tick();

    compare_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
